// File: rtl/netlist_eval_sched.sv
// Round-robin scheduler that time-shares one combinational netlist among four requesters.
// Define SIGNATURE_EN to enable the output-signature register (sig); otherwise sig reads 0.
module netlist_eval_sched #(
  parameter int SETTLE = 3,
  parameter int NREQ   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [55:0] req_vec,
  output logic [3:0]  req_ready,
  output logic [13:0] dut_in,
  input  logic [7:0]  dut_out,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [7:0]  sig,
  input  logic        sig_clr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [13:0] dut_in_q, dut_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        capture;

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic [13:0] gnt_vec;

  // Search starts one past the previous winner, so a continuously valid requester waits at most NREQ grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_grant_q + 2'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_vec = req_vec[13:0];
      2'd1:    gnt_vec = req_vec[27:14];
      2'd2:    gnt_vec = req_vec[41:28];
      default: gnt_vec = req_vec[55:42];
    endcase
  end

  assign req_ready = (state_q == ST_IDLE && gnt_found && !rst) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    dut_in_d     = dut_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          dut_in_d     = gnt_vec;
          last_grant_d = gnt_idx;
          cnt_d        = 4'(SETTLE - 1);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // cnt counts the remaining stable cycles; the capture edge is exactly SETTLE edges after dut_in loaded.
        if (cnt_q == 4'd0) begin
          capture     = 1'b1;
          rsp_data_d  = dut_out;
          rsp_id_d    = last_grant_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 2'd3;
      dut_in_q     <= 14'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 2'd0;
      rsp_data_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      dut_in_q     <= dut_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SIGNATURE_EN
  logic [7:0] sig_q, sig_d;

  function automatic logic [7:0] sig_next(input logic [7:0] s, input logic [7:0] d);
    sig_next = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
  endfunction

  always_comb begin
    sig_d = sig_q;
    if (sig_clr) begin
      sig_d = 8'h00;
    end else if (capture) begin
      sig_d = sig_next(sig_q, dut_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  logic [1:0] unused_sig_in;
  assign unused_sig_in = {sig_clr, capture};
  assign sig           = 8'h00;
`endif

endmodule

// File: tb/tb_netlist_eval_sched.sv
// Randomized self-checking bench for netlist_eval_sched against a transaction-level reference model.
module tb_netlist_eval_sched;
  localparam int SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [55:0] req_vec;
  logic [3:0]  req_ready;
  logic [13:0] dut_in;
  logic [7:0]  dut_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        busy;
  logic [7:0]  sig;
  logic        sig_clr;

  always #5 clk = ~clk;

  netlist_eval_sched #(.SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_vec(req_vec), .req_ready(req_ready),
    .dut_in(dut_in), .dut_out(dut_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .sig(sig), .sig_clr(sig_clr)
  );

  // Netlist model: outputs are garbage until dut_in has been stable for SETTLE cycles.
  int age = 100;
  always @(posedge clk) age <= (|req_ready) ? 1 : ((age < 1000) ? age + 1 : age);
  assign dut_out = dut_in[7:0] ^ ((age < SETTLE) ? 8'h5A : 8'h00);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state (transaction level)
  bit          outstanding = 0;
  int          grant_cyc   = 0;
  int          cyc         = 0;
  logic [1:0]  last_m      = 2'd3;
  logic [1:0]  exp_id      = 2'd0;
  logic [7:0]  exp_data    = 8'd0;
  logic [13:0] dut_in_m    = 14'd0;
  logic [7:0]  sig_m       = 8'd0;
  logic [3:0]  granted     = 4'd0;
  bit          rsp_done    = 0;
  int          dut_log[$];
  int          dut_cyc[$];

  function automatic int rr_pick(input logic [3:0] v, input logic [1:0] last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last) + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] sig_ref(input logic [7:0] s, input logic [7:0] d);
    int t;
    t = (int'(s) * 2) % 256;
    if (s >= 8'd128) t = t ^ 32'h1D;
    return 8'(t) ^ d;
  endfunction

  task automatic model_reset();
    outstanding = 0;
    last_m      = 2'd3;
    dut_in_m    = 14'd0;
    sig_m       = 8'd0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the coming edge.
  task automatic step();
    logic       expv;
    logic [3:0] exp_rdy;
    int         g;
    granted  = 4'd0;
    rsp_done = 0;
    expv = outstanding && (cyc >= grant_cyc + SETTLE + 1);
    chk("rsp_valid", rsp_valid, expv);
    if (expv) begin
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_data", rsp_data, exp_data);
    end
    chk("busy", busy, outstanding);
    g = rr_pick(req_valid, last_m);
    exp_rdy = 4'd0;
    if (!outstanding && !rst && g >= 0) exp_rdy = 4'b0001 << g;
    chk("req_ready", req_ready, exp_rdy);
    chk("dut_in", dut_in, dut_in_m);
    chk("sig", sig, sig_m);
    for (int j = 0; j < 4; j++) begin
      if (req_ready[j]) begin
        dut_log.push_back(j);
        dut_cyc.push_back(cyc);
      end
    end
    if (rst) begin
      model_reset();
    end else begin
`ifdef SIGNATURE_EN
      if (sig_clr) sig_m = 8'd0;
      else if (outstanding && cyc == grant_cyc + SETTLE) sig_m = sig_ref(sig_m, exp_data);
`endif
      if (expv && rsp_ready) begin
        outstanding = 0;
        rsp_done    = 1;
      end
      if (exp_rdy != 4'd0) begin
        outstanding = 1;
        grant_cyc   = cyc;
        exp_id      = 2'(g);
        exp_data    = req_vec[14*g +: 8];
        dut_in_m    = req_vec[14*g +: 14];
        last_m      = 2'(g);
        granted[g]  = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input logic [13:0] vec);
    int n;
    bit done;
    req_vec[14*idx +: 14] = vec;
    req_valid = 4'b0001 << idx;
    rsp_ready = 1'b1;
    done = 0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      if (granted[idx]) req_valid[idx] = 1'b0;
      if (rsp_done) done = 1;
      n++;
    end
    if (!done) chk("txn_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    n = 0;
    while (outstanding && n < 40) begin
      tick();
      n++;
    end
    if (outstanding) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_rdy, t_rsp, n;
    bit seen, found;
    logic [7:0] hd;
    logic [1:0] hid;

    rst = 1'b1; req_valid = 4'd0; req_vec = 56'd0; rsp_ready = 1'b0; sig_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'd0);
    chk("rst_dut_in", dut_in, 14'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_data", rsp_data, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sig", sig, 8'd0);
    @(posedge clk); #1;

    // Single request from requester 0
    req_vec[13:0] = 14'h1234; req_valid = 4'b0001; rsp_ready = 1'b1;
    t_rdy = -1; t_rsp = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready == 4'b0001 && t_rdy < 0) t_rdy = i;
      if (t_rdy >= 0 && i == t_rdy + 1) chk("s1_dut_in", dut_in, 14'h1234);
      if (rsp_valid && t_rsp < 0) begin
        t_rsp = i;
        chk("s1_rsp_id", rsp_id, 2'd0);
        chk("s1_rsp_data", rsp_data, 8'h34);
      end
      step();
      @(posedge clk); #1;
      if (granted[0]) req_valid[0] = 1'b0;
    end
    chk("s1_grant_seen", (t_rdy >= 0), 1);
    chk("s1_latency", t_rsp - t_rdy, SETTLE + 1);

    // Reset, then all four continuously valid
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_vec[14*i +: 14] = 14'($urandom);
    dut_log.delete(); dut_cyc.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      for (int j = 0; j < 4; j++) if (granted[j]) req_vec[14*j +: 14] = 14'($urandom);
    end
    chk("s2_count", (dut_log.size() >= 5), 1);
    if (dut_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("s2_order", dut_log[i], i % 4);
      for (int i = 1; i < 5; i++) chk("s2_gap", dut_cyc[i] - dut_cyc[i-1], SETTLE + 2);
    end

    // Consumer stalls
    rsp_ready = 1'b0; seen = 0; hd = 8'd0; hid = 2'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; hd = rsp_data; hid = rsp_id;
        end else begin
          chk("s3_data_hold", rsp_data, hd);
          chk("s3_id_hold", rsp_id, hid);
        end
        chk("s3_busy", busy, 1'b1);
        chk("s3_ready_low", req_ready, 4'd0);
      end
      step();
      @(posedge clk); #1;
    end
    chk("s3_seen", seen, 1);

    // Reset in the second SETTLE cycle
    rsp_ready = 1'b1; found = 0; n = 0;
    while (!found && n < 30) begin
      if (outstanding && cyc == grant_cyc + 2) found = 1;
      else begin
        tick();
        for (int j = 0; j < 4; j++) if (granted[j]) req_vec[14*j +: 14] = 14'($urandom);
        n++;
      end
    end
    chk("s4_reach", found, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("s4_rsp_valid", rsp_valid, 1'b0);
    chk("s4_dut_in", dut_in, 14'd0);
    chk("s4_rsp_id", rsp_id, 2'd0);
    chk("s4_rsp_data", rsp_data, 8'd0);
    chk("s4_busy", busy, 1'b0);
    chk("s4_sig", sig, 8'd0);
    chk("s4_first_grant", req_ready, 4'b0001);
    step();
    @(posedge clk); #1;
    req_valid = 4'd0;
    drain();

    // Signature sequence
    sig_clr = 1'b1; tick(); sig_clr = 1'b0;
    run_txn(1, 14'h00A5);
    tick();
`ifdef SIGNATURE_EN
    chk("s5_sig_a5", sig, 8'hA5);
`else
    chk("s5_sig_a5", sig, 8'h00);
`endif
    run_txn(2, 14'h3F00);
    tick();
`ifdef SIGNATURE_EN
    chk("s5_sig_57", sig, 8'h57);
`else
    chk("s5_sig_57", sig, 8'h00);
`endif
    sig_clr = 1'b1; tick(); sig_clr = 1'b0;
    chk("s5_sig_clr", sig, 8'h00);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (granted[i]) begin
          req_valid[i] = 1'($urandom % 2);
          req_vec[14*i +: 14] = 14'($urandom);
        end else if (!req_valid[i]) begin
          if ($urandom % 4 == 0) begin
            req_valid[i] = 1'b1;
            req_vec[14*i +: 14] = 14'($urandom);
          end
        end else if ($urandom % 32 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = (($urandom % 3) != 0);
      sig_clr   = (($urandom % 25) == 0);
      rst       = (($urandom % 500) == 0);
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
